ycr_rsp_router: RTL and testbench

Response-side companion to the 4-requester round-robin core-interface arbiter. Records the requester ID of every command accepted downstream (`req_ack`) in an in-order ID FIFO. Routes each downstream response (`lack`, read data, error) back to the owning requester one cycle later. Sits between the shared memory/bus port and the four core-side response interfaces, allowing up to DEPTH outstanding transactions.

---
 rtl/ycr_rsp_router.sv | 111 +++++++++++
 tb/tb_ycr_rsp_router.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr_rsp_router.sv
// Response router: keeps an in-order FIFO of accepted requester IDs and steers
// each downstream response (ack, data, error) to the owning requester one cycle later.
module ycr_rsp_router #(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cmd_vld,
   input  logic [1:0]    cmd_id,
   input  logic          rsp_ack,
   input  logic [DW-1:0] rsp_rdata,
   input  logic          rsp_err,
   input  logic          err_clr,
   output logic [3:0]    core_ack,
   output logic [DW-1:0] core_rdata,
   output logic [3:0]    core_err,
   output logic          cmd_stall,
   output logic          outst_empty,
   output logic          ovf_err,
   output logic          unexp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [1:0]    id_mem_q [DEPTH];

   logic [3:0]    core_ack_q, core_ack_d;
   logic [3:0]    core_err_q, core_err_d;
   logic [DW-1:0] core_rdata_q, core_rdata_d;
   logic          ovf_q, ovf_d;
   logic          unexp_q, unexp_d;

   logic          full, empty, push, pop;
   logic [1:0]    head_id;

   assign full    = (cnt_q == FULL_CNT);
   assign empty   = (cnt_q == '0);
   // A pop frees a slot in the same cycle, so a push at full is still accepted.
   assign pop     = rsp_ack && !empty;
   assign push    = cmd_vld && (!full || pop);
   assign head_id = id_mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      core_ack_d   = '0;
      core_err_d   = '0;
      core_rdata_d = core_rdata_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      if (pop) begin
         core_ack_d   = 4'b0001 << head_id;
         core_err_d   = rsp_err ? (4'b0001 << head_id) : 4'b0000;
         core_rdata_d = rsp_rdata;
      end

      // Set events take priority over a same-cycle clear.
      ovf_d   = (cmd_vld && full && !pop) || (ovf_q && !err_clr);
      unexp_d = (rsp_ack && empty) || (unexp_q && !err_clr);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         core_ack_q   <= '0;
         core_err_q   <= '0;
         core_rdata_q <= '0;
         ovf_q        <= 1'b0;
         unexp_q      <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         core_ack_q   <= core_ack_d;
         core_err_q   <= core_err_d;
         core_rdata_q <= core_rdata_d;
         ovf_q        <= ovf_d;
         unexp_q      <= unexp_d;
      end
   end

   // ID storage needs no reset: entries are only read once cnt marks them valid.
   always_ff @(posedge clk) begin
      if (push) id_mem_q[wr_ptr_q] <= cmd_id;
   end

   assign core_ack    = core_ack_q;
   assign core_err    = core_err_q;
   assign core_rdata  = core_rdata_q;
   assign cmd_stall   = full;
   assign outst_empty = empty;
   assign ovf_err     = ovf_q;
   assign unexp_err   = unexp_q;

endmodule

// File: tb/tb_ycr_rsp_router.sv
// Bench for ycr_rsp_router: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ycr_rsp_router;

   localparam int DEPTH = 4;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          cmd_vld = 1'b0;
   logic [1:0]    cmd_id = 2'd0;
   logic          rsp_ack = 1'b0;
   logic [DW-1:0] rsp_rdata = '0;
   logic          rsp_err = 1'b0;
   logic          err_clr = 1'b0;
   logic [3:0]    core_ack;
   logic [DW-1:0] core_rdata;
   logic [3:0]    core_err;
   logic          cmd_stall;
   logic          outst_empty;
   logic          ovf_err;
   logic          unexp_err;

   ycr_rsp_router #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_vld(cmd_vld), .cmd_id(cmd_id),
      .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .err_clr(err_clr),
      .core_ack(core_ack), .core_rdata(core_rdata), .core_err(core_err),
      .cmd_stall(cmd_stall), .outst_empty(outst_empty),
      .ovf_err(ovf_err), .unexp_err(unexp_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: a queue of outstanding IDs and the values the outputs must show.
   int unsigned   mq[$];
   logic [3:0]    m_ack = '0;
   logic [3:0]    m_err = '0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_ovf = 1'b0;
   logic          m_unexp = 1'b0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mq.delete();
         m_ack = '0; m_err = '0; m_rdata = '0; m_ovf = 1'b0; m_unexp = 1'b0;
      end else begin : model_step
         logic ovf_set, unexp_set;
         int unsigned k;
         ovf_set = 1'b0; unexp_set = 1'b0;
         m_ack = '0; m_err = '0;
         if (rsp_ack) begin
            if (mq.size() > 0) begin
               k = mq.pop_front();
               m_ack = 4'(1 << k);
               m_err = rsp_err ? m_ack : 4'b0000;
               m_rdata = rsp_rdata;
            end else begin
               unexp_set = 1'b1;
            end
         end
         if (cmd_vld) begin
            if (mq.size() < DEPTH) mq.push_back(32'(cmd_id));
            else ovf_set = 1'b1;
         end
         m_ovf   = ovf_set   | (m_ovf   & ~err_clr);
         m_unexp = unexp_set | (m_unexp & ~err_clr);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("core_ack", 32'(core_ack), 32'(m_ack));
         check("core_err", 32'(core_err), 32'(m_err));
         check("core_rdata", core_rdata, m_rdata);
         check("cmd_stall", 32'(cmd_stall), 32'(mq.size() == DEPTH));
         check("outst_empty", 32'(outst_empty), 32'(mq.size() == 0));
         check("ovf_err", 32'(ovf_err), 32'(m_ovf));
         check("unexp_err", 32'(unexp_err), 32'(m_unexp));
      end
   end

   task automatic cyc(input logic v, input logic [1:0] id, input logic a,
                      input logic [DW-1:0] d, input logic e, input logic c);
      cmd_vld = v; cmd_id = id; rsp_ack = a; rsp_rdata = d; rsp_err = e; err_clr = c;
      @(posedge clk);
      #1;
      cmd_vld = 1'b0; rsp_ack = 1'b0; rsp_err = 1'b0; err_clr = 1'b0;
   endtask

   task automatic push(input logic [1:0] id);
      cyc(1'b1, id, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic rsp(input logic [DW-1:0] d, input logic e);
      cyc(1'b0, 2'd0, 1'b1, d, e, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic clr();
      cyc(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [3:0] exp_ack [4];
      int cnt;
      int op;

      // Reset
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      #1;
      check("rst_empty", 32'(outst_empty), 32'd1);
      check("rst_stall", 32'(cmd_stall), 32'd0);
      check("rst_ack", 32'(core_ack), 32'd0);
      check("rst_rdata", core_rdata, 32'd0);
      rstn = 1'b1;
      idle(1);

      // Single read: command at T0, response at T3
      push(2'd2);
      idle(2);
      check("single_notempty", 32'(outst_empty), 32'd0);
      rsp(32'hDEADBEEF, 1'b0);
      check("single_ack", 32'(core_ack), 32'h4);
      check("single_rdata", core_rdata, 32'hDEADBEEF);
      check("single_err", 32'(core_err), 32'h0);
      check("single_empty", 32'(outst_empty), 32'd1);
      idle(1);
      check("single_ack_pulse", 32'(core_ack), 32'h0);

      // Fill and drain, error on the second response
      push(2'd0); push(2'd3); push(2'd1);
      check("fill_stall3", 32'(cmd_stall), 32'd0);
      push(2'd2);
      check("fill_stall4", 32'(cmd_stall), 32'd1);
      exp_ack[0] = 4'b0001; exp_ack[1] = 4'b1000; exp_ack[2] = 4'b0010; exp_ack[3] = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         rsp(32'h1000 + 32'(i), i == 1);
         check("drain_ack", 32'(core_ack), 32'(exp_ack[i]));
         check("drain_err", 32'(core_err), (i == 1) ? 32'h8 : 32'h0);
         check("drain_rdata", core_rdata, 32'h1000 + 32'(i));
      end
      check("drain_empty", 32'(outst_empty), 32'd1);

      // Full plus simultaneous push and pop
      push(2'd0); push(2'd1); push(2'd2); push(2'd3);
      cyc(1'b1, 2'd1, 1'b1, 32'h55AA0000, 1'b0, 1'b0);
      check("simul_ack", 32'(core_ack), 32'h1);
      check("simul_stall", 32'(cmd_stall), 32'd1);
      check("simul_ovf", 32'(ovf_err), 32'd0);
      exp_ack[0] = 4'b0010; exp_ack[1] = 4'b0100; exp_ack[2] = 4'b1000; exp_ack[3] = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         rsp(32'h2000 + 32'(i), 1'b0);
         check("simul_drain_ack", 32'(core_ack), 32'(exp_ack[i]));
      end

      // Overflow: command dropped at full
      push(2'd3); push(2'd2); push(2'd1); push(2'd0);
      push(2'd3);
      check("ovf_set", 32'(ovf_err), 32'd1);
      check("ovf_stall", 32'(cmd_stall), 32'd1);
      exp_ack[0] = 4'b1000; exp_ack[1] = 4'b0100; exp_ack[2] = 4'b0010; exp_ack[3] = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         rsp(32'h3000 + 32'(i), 1'b0);
         check("ovf_drain_ack", 32'(core_ack), 32'(exp_ack[i]));
      end
      check("ovf_empty", 32'(outst_empty), 32'd1);
      check("ovf_sticky", 32'(ovf_err), 32'd1);
      clr();
      check("ovf_clr", 32'(ovf_err), 32'd0);

      // Unexpected response while empty
      rsp(32'h4000, 1'b0);
      check("unexp_ack", 32'(core_ack), 32'h0);
      check("unexp_set", 32'(unexp_err), 32'd1);
      clr();
      check("unexp_clr", 32'(unexp_err), 32'd0);
      cyc(1'b0, 2'd0, 1'b1, 32'h4001, 1'b0, 1'b1);
      check("unexp_set_wins", 32'(unexp_err), 32'd1);
      clr();

      // Empty FIFO with same-cycle push and response
      cyc(1'b1, 2'd3, 1'b1, 32'h4100, 1'b0, 1'b0);
      check("emptypush_ack", 32'(core_ack), 32'h0);
      check("emptypush_unexp", 32'(unexp_err), 32'd1);
      check("emptypush_notempty", 32'(outst_empty), 32'd0);
      rsp(32'h4101, 1'b0);
      check("emptypush_route", 32'(core_ack), 32'h8);
      clr();

      // Reset mid-flight
      push(2'd1); push(2'd2);
      rstn = 1'b0;
      #1;
      check("midrst_empty", 32'(outst_empty), 32'd1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      rsp(32'h5000, 1'b0);
      check("midrst_ack", 32'(core_ack), 32'h0);
      check("midrst_unexp", 32'(unexp_err), 32'd1);
      check("midrst_empty2", 32'(outst_empty), 32'd1);
      clr();

      // Pointer wrap with occupancy kept in 1..DEPTH-1
      push(2'($urandom_range(0, 3)));
      cnt = 1;
      for (int i = 0; i < 6 * DEPTH; i++) begin
         op = $urandom_range(0, 2);
         if (cnt == 1 && op == 1) op = 2;
         if (cnt == DEPTH - 1 && op == 0) op = 2;
         cyc(op != 1, 2'($urandom_range(0, 3)), op != 0, $urandom, 1'($urandom_range(0, 1)), 1'b0);
         if (op == 0) cnt++;
         if (op == 1) cnt--;
      end
      while (cnt > 0) begin
         rsp($urandom, 1'b0);
         cnt--;
      end
      check("wrap_empty", 32'(outst_empty), 32'd1);
      check("wrap_unexp", 32'(unexp_err), 32'd0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
